// File: rtl/door_lock_pkg.sv
// door_lock_pkg: shared state codes, default timing and helpers for the door lock
package door_lock_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_WAIT    = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    localparam int unsigned DEF_CMP_WAIT       = 2;
    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_UNLOCK_CYCLES  = 500_000_000;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 1_500_000_000;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return v == 2'd3 ? v : v + 2'd1;
    endfunction
endpackage

// File: rtl/door_lock_timer.sv
// door_lock_timer: loadable 32-bit down-counter, done on the final counted cycle
module door_lock_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        done
);
    logic [31:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 32'd1;
    end

    assign done = count == 32'd1;
endmodule

// File: rtl/door_lock_fsm.sv
// door_lock_fsm: password door lock controller with comparator handshake and retry lockout
module door_lock_fsm
    import door_lock_pkg::*;
#(
    parameter int unsigned CMP_WAIT       = DEF_CMP_WAIT,
    parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       check_btn,
    output logic       cmp_check,
    input  logic       cmp_match,
    output logic       door_unlock,
    output logic       locked_out,
    output logic [1:0] fail_count,
    output logic [2:0] state_dbg
);
    localparam logic [1:0] MAX_F = 2'(MAX_FAILS);

    state_t      state;
    logic        btn_q;
    logic        rise;
    logic        load;
    logic        done;
    logic [31:0] load_val;

    assign rise      = check_btn & ~btn_q;
    assign state_dbg = state;

    // timer reloads on entry to every timed state
    always_comb begin
        load     = (state == S_CHECK) || (state == S_WAIT && done && cmp_match) ||
                   (state == S_FAIL && fail_count >= MAX_F);
        load_val = state == S_CHECK ? CMP_WAIT : state == S_WAIT ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    end

    door_lock_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            btn_q       <= 1'b0;
            fail_count  <= 2'd0;
            cmp_check   <= 1'b0;
            door_unlock <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            btn_q     <= check_btn;
            cmp_check <= 1'b0;
            case (state)
                S_IDLE: if (rise) begin
                    state     <= S_CHECK;
                    cmp_check <= 1'b1;
                end
                S_CHECK: state <= S_WAIT;
                S_WAIT: if (done) begin
                    if (cmp_match) begin
                        state       <= S_OPEN;
                        door_unlock <= 1'b1;
                        fail_count  <= 2'd0;
                    end else begin
                        state      <= S_FAIL;
                        fail_count <= sat_inc(fail_count);
                    end
                end
                S_OPEN: if (done) begin
                    state       <= S_IDLE;
                    door_unlock <= 1'b0;
                end
                S_FAIL: if (fail_count >= MAX_F) begin
                    state      <= S_LOCKOUT;
                    locked_out <= 1'b1;
                end else begin
                    state <= S_IDLE;
                end
                S_LOCKOUT: if (done) begin
                    state      <= S_IDLE;
                    locked_out <= 1'b0;
                    fail_count <= 2'd0;
                end
                default: begin
                    state       <= S_IDLE;
                    door_unlock <= 1'b0;
                    locked_out  <= 1'b0;
                    fail_count  <= 2'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_door_lock_fsm.sv
// tb_door_lock_fsm: directed bench with a timeline-window reference model for door_lock_fsm
module tb_door_lock_fsm;
    localparam int CW   = 2;
    localparam int MAXF = 3;
    localparam int UNL  = 8;
    localparam int LOCK = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       check_btn;
    logic       cmp_check;
    logic       cmp_match;
    logic       door_unlock;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    door_lock_fsm #(
        .CMP_WAIT       (CW),
        .MAX_FAILS      (MAXF),
        .UNLOCK_CYCLES  (UNL),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .check_btn   (check_btn),
        .cmp_check   (cmp_check),
        .cmp_match   (cmp_match),
        .door_unlock (door_unlock),
        .locked_out  (locked_out),
        .fail_count  (fail_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // model: each accepted request opens time windows computed from its start cycle
    int cyc, idle_from, t_chk, m_res, open_lo, open_hi, lock_lo, lock_hi, fail_at, fc_clr_at, fc;
    bit pend, prev_btn;

    task automatic model_reset();
        cyc = 0; idle_from = 0; t_chk = -1000; m_res = -1000; fail_at = -1000;
        open_lo = 0; open_hi = -1; lock_lo = 0; lock_hi = -1; fc_clr_at = -1;
        fc = 0; pend = 0; prev_btn = 0;
    endtask

    task automatic model_step();
        cyc++;
        if (cyc == fc_clr_at) fc = 0;
        if (pend && cyc == m_res) begin
            pend = 0;
            if (cmp_match) begin
                open_lo = cyc; open_hi = cyc + UNL - 1; fc = 0; idle_from = cyc + UNL;
            end else begin
                fail_at = cyc;
                fc = fc == 3 ? 3 : fc + 1;
                if (fc >= MAXF) begin
                    lock_lo = cyc + 1; lock_hi = cyc + LOCK;
                    fc_clr_at = cyc + LOCK + 1; idle_from = cyc + LOCK + 1;
                end else begin
                    idle_from = cyc + 1;
                end
            end
        end else if (!pend && check_btn && !prev_btn && cyc - 1 >= idle_from) begin
            pend = 1; t_chk = cyc; m_res = cyc + CW + 1;
        end
        prev_btn = check_btn;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (model cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
        end
    endtask

    int n_chk = 0, unl_run = 0, last_unl = 0, lck_run = 0, last_lck = 0, lock_runs = 0;

    initial begin
        int e_unl, e_lck, e_st;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                e_unl = int'(cyc >= open_lo && cyc <= open_hi);
                e_lck = int'(cyc >= lock_lo && cyc <= lock_hi);
                e_st  = cyc == t_chk ? 1 : (pend && cyc > t_chk) ? 2 : e_unl != 0 ? 3 :
                        cyc == fail_at ? 4 : e_lck != 0 ? 5 : 0;
                check("cmp_check", 32'(cmp_check), 32'(cyc == t_chk));
                check("door_unlock", 32'(door_unlock), e_unl);
                check("locked_out", 32'(locked_out), e_lck);
                check("fail_count", 32'(fail_count), fc);
                check("state_dbg", 32'(state_dbg), e_st);
                if (cmp_check) n_chk++;
                if (door_unlock) unl_run++;
                else if (unl_run != 0) begin last_unl = unl_run; unl_run = 0; end
                if (locked_out) begin if (lck_run == 0) lock_runs++; lck_run++; end
                else if (lck_run != 0) begin last_lck = lck_run; lck_run = 0; end
            end else begin
                unl_run = 0; lck_run = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic entry(input logic match, input int fc_exp);
        cmp_match = match; check_btn = 1'b1;
        tick(1);
        check("lit_chk_pulse", 32'(cmp_check), 1);
        check_btn = 1'b0;
        tick(3);
        if (match) begin
            check("lit_open_unlock", 32'(door_unlock), 1);
            check("lit_open_state", 32'(state_dbg), 3);
        end else begin
            check("lit_fail_state", 32'(state_dbg), 4);
            check("lit_fail_count", 32'(fail_count), fc_exp);
        end
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        check("lit_rst_outs", {24'd0, cmp_check, door_unlock, locked_out, fail_count, state_dbg}, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0, r0;
        rst_n = 1'b0; check_btn = 1'b0; cmp_match = 1'b0;
        #3;
        check("lit_reset_state", {24'd0, cmp_check, door_unlock, locked_out, fail_count, state_dbg}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        entry(1'b1, 0);
        tick(8);
        check("lit_unlock_end", 32'(door_unlock), 0);
        check("lit_unlock_len", last_unl, UNL);
        check("lit_fc_after_open", 32'(fail_count), 0);
        entry(1'b0, 1); tick(1);
        entry(1'b0, 2); tick(1);
        entry(1'b0, 3); tick(1);
        check("lit_locked", 32'(locked_out), 1);
        n0 = n_chk;
        check_btn = 1'b1; tick(2); check_btn = 1'b0; tick(2);
        check_btn = 1'b1; tick(1); check_btn = 1'b0; tick(11);
        check("lit_lock_end", 32'(locked_out), 0);
        check("lit_lock_len", last_lck, LOCK);
        check("lit_fc_after_lock", 32'(fail_count), 0);
        check("lit_no_pulse_lockout", n_chk, n0);
        r0 = lock_runs;
        entry(1'b0, 1); tick(1);
        entry(1'b0, 2); tick(1);
        entry(1'b1, 0);
        check("lit_fc_cleared_open", 32'(fail_count), 0);
        tick(8);
        check("lit_no_lockout", lock_runs, r0);
        n0 = n_chk;
        cmp_match = 1'b1; check_btn = 1'b1; tick(1);
        check_btn = 1'b0; tick(1);
        check_btn = 1'b1; tick(1);
        check_btn = 1'b0; tick(2);
        check_btn = 1'b1; tick(1);
        check_btn = 1'b0; tick(8);
        check("lit_ignored_edges", n_chk, n0 + 1);
        n0 = n_chk;
        check_btn = 1'b1; tick(20);
        check("lit_held_once", n_chk, n0 + 1);
        check_btn = 1'b0; tick(2);
        entry(1'b1, 0);
        tick(2);
        pulse_reset();
        entry(1'b1, 0);
        tick(8);
        check("lit_fresh_unlock_len", last_unl, UNL);
        entry(1'b0, 1); tick(1);
        entry(1'b0, 2); tick(1);
        entry(1'b0, 3); tick(5);
        check("lit_mid_lockout", 32'(locked_out), 1);
        pulse_reset();
        entry(1'b0, 1);
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/door_lock_fsm.md
DOOR_LOCK_FSM -- requirements
Module: door_lock_fsm

Interface
REQ-001 Parameter CMP_WAIT, default 2, cycles from cmp_check pulse to valid cmp_match sample (range 1..15).
REQ-002 Parameter MAX_FAILS, default 3, consecutive wrong entries that trigger lockout (range 1..3).
REQ-003 Parameter UNLOCK_CYCLES, default 500_000_000, door-open hold time in clk cycles.
REQ-004 Parameter LOCKOUT_CYCLES, default 1_500_000_000, lockout duration in clk cycles.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 check_btn  input  1  user "enter" button, synchronous level, debounced upstream.
REQ-008 cmp_check  output  1  one-cycle request pulse to password comparator.
REQ-009 cmp_match  input  1  comparator result, sampled only at end of WAIT.
REQ-010 door_unlock  output  1  high while door actuator released.
REQ-011 locked_out  output  1  high during lockout.
REQ-012 fail_count  output  2  current consecutive-failure count.
REQ-013 state_dbg  output  3  encoded FSM state for LEDs/ILA.

Function
REQ-014 FSM states: IDLE=0, CHECK=1, WAIT=2, OPEN=3, FAIL=4, LOCKOUT=5; codes SHALL appear on state_dbg.
REQ-015 Rising edge of check_btn (registered previous-value detect) in IDLE SHALL move to CHECK next cycle; edges in any other state SHALL be ignored, not queued.
REQ-016 CHECK SHALL last exactly one cycle with cmp_check=1, then enter WAIT; cmp_check SHALL be 0 in every other state.
REQ-017 WAIT SHALL last exactly CMP_WAIT cycles (down-counter), then sample cmp_match: 1 -> OPEN, 0 -> FAIL.
REQ-018 Entering OPEN SHALL clear fail_count to 0 and assert door_unlock for exactly UNLOCK_CYCLES cycles, then return to IDLE with door_unlock=0.
REQ-019 FAIL SHALL last one cycle and increment fail_count (saturating at 3); if new count >= MAX_FAILS -> LOCKOUT, else -> IDLE.
REQ-020 LOCKOUT SHALL assert locked_out for exactly LOCKOUT_CYCLES cycles, then clear fail_count to 0 and return to IDLE.
REQ-021 Timer SHALL be one shared 32-bit down-counter loaded on state entry; terminal condition is count==1 on the final cycle, no wrap below 0.
REQ-022 door_unlock and locked_out SHALL be registered, mutually exclusive, and never high simultaneously.
REQ-023 check_btn held high across states SHALL NOT produce a second request; a new low->high transition is required after return to IDLE.
REQ-024 Unencodable state SHALL recover to IDLE next cycle with all outputs deasserted.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, timer=0, fail_count=0, cmp_check=0, door_unlock=0, locked_out=0, button-edge register=0, state_dbg=0.
REQ-026 Reset during OPEN or LOCKOUT SHALL abort the timer; no resumption after release.
REQ-027 Deassertion SHALL be synchronized to clk by the top-level reset synchronizer; block performs no internal synchronization.

Structure
REQ-028 State encoding localparams and default timing constants SHALL live in shared package door_lock_pkg, reused by comparator/top.
REQ-029 One sub-module door_lock_timer (loadable 32-bit down-counter with done flag) is natural; edge detect and FSM remain inline.
REQ-030 Target 120-400 RTL lines; no latches, single always block per registered group.

Verification (bench params CMP_WAIT=2, MAX_FAILS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16)
REQ-031 Correct entry: check_btn edge, cmp_match=1 -> cmp_check pulse 1 cycle after edge, door_unlock high 8 cycles starting 4 cycles after edge, fail_count=0.
REQ-032 Three wrong entries (cmp_match=0) -> fail_count 1,2, then locked_out high 16 cycles, fail_count=0 and IDLE after.
REQ-033 Two wrong then one correct -> fail_count 1,2 then 0 on OPEN; locked_out never asserts.
REQ-034 Button edges during WAIT, OPEN and LOCKOUT -> no extra cmp_check pulses; held button produces exactly one request.
REQ-035 rst_n pulsed low mid-OPEN (cycle 3 of 8) and mid-LOCKOUT -> all outputs 0 within same cycle, state_dbg=0, next edge starts fresh.
